muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, in parallel with the ALU, which carries no M-extension datapath. Takes the same decoded rs1/rs2 operands and funct3, computes over a fixed number of cycles, and holds the pipeline through `busy`. On `done` it returns a 32-bit result to the EX/MEM result mux. One operation is in flight at a time.

## Interface
- `XLEN`, 32: operand/result width; matches `` `RegBus ``.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in1`  in  XLEN  rs1 value (multiplicand/dividend); sampled with `start`.
- `in2`  in  XLEN  rs2 value (multiplier/divisor); sampled with `start`.
- `flush`  in  1  abort (branch mispredict/trap).
- `busy`  out  1  high from the cycle after accept until the cycle `done` is high, inclusive; drives the pipeline stall.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  XLEN  registered result; holds until next accept.

## Operation
- States:
  - IDLE → CALC on `start` && !`flush`.
  - CALC (32 iterations, counter 0..31) → FIX.
  - FIX → DONE.
  - DONE → IDLE.
- Accept (IDLE, `start`=1): latch `op` and operand magnitudes, plus the negate flags.
  - Signed operand: MUL/MULH/DIV/REM both operands; MULHSU `in1` only.
  - Unsigned: MULHU, DIVU, REMU.
- Multiply: shift-add, 1 bit/cycle into a 64-bit accumulator. FIX negates the product if exactly one operand was negative. MUL returns [31:0]; the others return [63:32].
- Divide: restoring, 1 quotient bit/cycle, 32-bit remainder + 1 guard bit. In FIX:
  - quotient negated if the operand signs differ;
  - remainder takes the dividend's sign.
- Special cases, resolved in FIX with the same latency:
  - divisor 0: quotient 0xFFFFFFFF, remainder = original `in1`.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `start` while not IDLE: ignored. The pipeline must hold `start` low while `busy`.
- `flush` in any state: next state IDLE. No `done`; `result` keeps its previous value.
- `flush` and `start` in the same IDLE cycle: flush wins, nothing accepted.

## Timing
- Reset values:
  - state IDLE, counter 0, accumulator 0;
  - `busy`=0, `done`=0, `result`=0.
- Accept edge = cycle 0.
  - `busy`=1 cycles 1..34.
  - CALC cycles 1..32, FIX cycle 33.
  - `result` register written at the end of FIX; `done`=1 and `result` valid in cycle 34.
  - Back in IDLE in cycle 35.
- Fixed latency 34 cycles for every op, including special cases.
- Back-to-back: a new `start` is accepted no earlier than cycle 35.
- `result` stable from cycle 34 until the next accept's FIX write.
- Reset mid-operation: immediate return to reset values, no `done`.

## Configuration
- `MULDIV_DIV_EN` defined: all eight ops supported as above.
- Not defined:
  - divider datapath, remainder register and divide special-case logic are omitted;
  - ops 100–111 are still accepted and follow the same 34-cycle sequence (stall behaviour unchanged), returning `result`=0;
  - multiply ops are unaffected.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD, start at cycle 0 → `done` exactly at cycle 34, `result`=0xFFFFFFEB, `busy` high cycles 1..34.
- MULH/MULHU/MULHSU with 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000 / 0xFFFFFFFE / 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Abort/start interaction:
  - MUL started, `flush` at cycle 10 → IDLE at cycle 11, no `done`, `result` unchanged.
  - `start`+`flush` together → not accepted.
  - `start` pulsed while busy → ignored.
- `rst_n` low at cycle 20 of a DIV → `busy`/`done`/`result` 0 immediately. Without `MULDIV_DIV_EN`: DIVU 100/7 → `done` at 34, `result`=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider, fixed 34-cycle latency.
// Define MULDIV_DIV_EN to build the divider; without it divide ops still stall 34 cycles and return 0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  logic              sgn1;
  logic              sgn2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      3'b010:  sgn1 = 1'b1;
      default: ;
    endcase
  end

  assign mag1 = (sgn1 && in1[XLEN-1]) ? -in1 : in1;
  assign mag2 = (sgn2 && in2[XLEN-1]) ? -in2 : in2;

  // acc holds {partial product, remaining multiplier bits}; low half doubles as dividend/quotient.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign prod     = (neg_a ^ neg_b) ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] rem;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;

  assign rem_shift = {rem, acc[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd};
  // Signed overflow (MIN / -1) needs no special path: |MIN| / 1 re-negates to MIN with remainder 0.
  assign quot_fix  = (opnd == '0) ? '1 :
                     ((neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
  assign rem_fix   = neg_a ? -rem : rem;
  assign div_res   = op_q[1] ? rem_fix : quot_fix;
`else
  assign div_res   = '0;
`endif

  always_comb begin
    fix_res = div_res;
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef MULDIV_DIV_EN
      rem    <= '0;
`endif
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
            op_q  <= op;
            neg_a <= sgn1 && in1[XLEN-1];
            neg_b <= sgn2 && in2[XLEN-1];
            opnd  <= op[2] ? mag2 : mag1;
            acc   <= {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
`ifdef MULDIV_DIV_EN
            rem   <= '0;
`endif
          end
        end
        CALC: begin
          if (!op_q[2]) begin
            acc <= mul_next;
          end
`ifdef MULDIV_DIV_EN
          else if (!rem_diff[XLEN]) begin
            rem             <= rem_diff[XLEN-1:0];
            acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b1};
          end else begin
            rem             <= rem_shift[XLEN-1:0];
            acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b0};
          end
`endif
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
